axis_arbiter: RTL and testbench

AXIS_ARBITER -- requirements
Module: axis_arbiter

---
 rtl/axis_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/axis_arbiter.sv | 88 ++++++++
 tb/tb_axis_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkg
// Description : Shared defaults and FSM state type for the AXI-Stream arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_pkg;

    localparam int c_N_SRC_DEFAULT  = 4;
    localparam int c_DATA_W_DEFAULT = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick starting after the last grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import axis_pkg::*;
#(
    parameter int N_SRC = c_N_SRC_DEFAULT
) (
    input  logic [N_SRC-1:0]         i_req,
    input  logic [$clog2(N_SRC)-1:0] i_last_gnt,
    output logic [$clog2(N_SRC)-1:0] o_winner,
    output logic                     o_any_req
);

    localparam int c_IDX_W = $clog2(N_SRC);

    logic [c_IDX_W-1:0] w_idx;

    // Offsets 1..N_SRC visit every source once, ending with last_gnt itself.
    always_comb begin
        w_idx     = '0;
        o_winner  = '0;
        o_any_req = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            w_idx = c_IDX_W'((int'(i_last_gnt) + k) % N_SRC);
            if (!o_any_req && i_req[w_idx]) begin
                o_winner  = w_idx;
                o_any_req = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_arbiter
// Description : Packet-locked round-robin N:1 AXI-Stream arbiter, no datapath regs.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_arbiter
    import axis_pkg::*;
#(
    parameter int N_SRC  = c_N_SRC_DEFAULT,
    parameter int DATA_W = c_DATA_W_DEFAULT
) (
    input  logic                      axis_aclk,
    input  logic                      axis_arst,
    input  logic [N_SRC*DATA_W-1:0]   s_axis_tdata,
    input  logic [N_SRC-1:0]          s_axis_tvalid,
    input  logic [N_SRC-1:0]          s_axis_tlast,
    output logic [N_SRC-1:0]          s_axis_tready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    output logic [$clog2(N_SRC)-1:0]  m_axis_tid,
    input  logic                      m_axis_tready,
    output logic                      pkt_done
);

    localparam int                 c_IDX_W    = $clog2(N_SRC);
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(N_SRC - 1);

    state_t             r_state;
    logic [c_IDX_W-1:0] r_gnt_idx;
    logic [c_IDX_W-1:0] r_last_gnt;
    logic [c_IDX_W-1:0] w_winner;
    logic               w_any_req;
    logic               w_busy;
    logic               w_pkt_end;

    rr_arbiter #(
        .N_SRC (N_SRC)
    ) u_rr_arbiter (
        .i_req      (s_axis_tvalid),
        .i_last_gnt (r_last_gnt),
        .o_winner   (w_winner),
        .o_any_req  (w_any_req)
    );

    assign w_busy        = (r_state == BUSY);
    assign m_axis_tdata  = w_busy ? s_axis_tdata[int'(r_gnt_idx)*DATA_W +: DATA_W] : '0;
    assign m_axis_tvalid = w_busy & s_axis_tvalid[r_gnt_idx];
    assign m_axis_tlast  = w_busy & s_axis_tlast[r_gnt_idx];
    assign m_axis_tid    = r_gnt_idx;
    assign w_pkt_end     = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign pkt_done      = w_pkt_end;

    always_comb begin
        s_axis_tready = '0;
        if (w_busy) begin
            s_axis_tready[r_gnt_idx] = m_axis_tready;
        end
    end

    // Grant is held until a tlast beat actually transfers; valid gaps do not release it.
    always_ff @(posedge axis_aclk) begin
        if (axis_arst) begin
            r_state    <= IDLE;
            r_gnt_idx  <= '0;
            r_last_gnt <= c_LAST_RST;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_gnt_idx  <= w_winner;
                        r_last_gnt <= w_winner;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_pkt_end) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_arbiter
// Description : Scoreboard bench for axis_arbiter with per-source beat queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_arbiter;

    typedef struct packed {
        logic [1:0] tid;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_tdata  = '0;
    logic [3:0]  s_tvalid = '0;
    logic [3:0]  s_tlast  = '0;
    logic [3:0]  s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [1:0]  m_tid;
    logic        m_trdy = 1'b1;
    logic        pkt_done;

    int   errors = 0;
    int   checks = 0;
    int   n_done = 0;
    int   cyc    = 0;
    int   last_done_cyc = 0;
    exp_t sb[$];

    // Source stimulus entries: {valid, last, data}; valid=0 is a one-cycle gap.
    logic [9:0] smem [4][32];
    int         shead [4] = '{default: 0};
    int         stail [4] = '{default: 0};
    logic [3:0] cur_gap = '0;

    axis_arbiter #(
        .N_SRC  (4),
        .DATA_W (8)
    ) dut (
        .axis_aclk     (clk),
        .axis_arst     (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tid    (m_tid),
        .m_axis_tready (m_trdy),
        .pkt_done      (pkt_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_src(input int s, input logic v, input logic l, input logic [7:0] d);
        smem[s][stail[s]] = {v, l, d};
        stail[s]++;
    endtask

    task automatic push_exp(input logic [1:0] t, input logic [7:0] d, input logic l);
        sb.push_back({t, d, l});
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < 4; i++) if (shead[i] < stail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_empty(input string name);
        int n = 0;
        while ((sb.size() != 0 || !src_empty()) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s: timeout with %0d beats outstanding, expected 0", name, sb.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Source driver: advance a queue after a handshake or after a gap cycle.
    initial begin
        logic [3:0] xfer;
        logic [9:0] e;
        forever begin
            @(posedge clk);
            xfer = s_tvalid & s_tready;
            #1;
            for (int i = 0; i < 4; i++) begin
                if (shead[i] < stail[i] && (cur_gap[i] || xfer[i])) shead[i]++;
                if (shead[i] < stail[i]) begin
                    e = smem[i][shead[i]];
                    s_tvalid[i]       = e[9];
                    s_tlast[i]        = e[8];
                    s_tdata[i*8 +: 8] = e[7:0];
                    cur_gap[i]        = ~e[9];
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                    cur_gap[i]  = 1'b0;
                end
            end
        end
    end

    // Monitor: every transferred beat is matched against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_tvalid && m_trdy) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got tid %0h data %0h, expected no beat", m_tid, m_tdata);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_tid", 32'(m_tid), 32'(e.tid));
                        chk("beat_data", 32'(m_tdata), 32'(e.data));
                        chk("beat_last", 32'(m_tlast), 32'(e.last));
                    end
                    chk("pkt_done_on_xfer", 32'(pkt_done), 32'(m_tlast));
                    if (m_tlast) last_done_cyc = cyc;
                end else begin
                    chk("pkt_done_no_xfer", 32'(pkt_done), 32'd0);
                end
                if (m_tvalid) chk("ready_mirror", 32'(s_tready), 32'(4'(m_trdy) << m_tid));
                if (pkt_done) n_done++;
            end
        end
    end

    initial begin
        int c0;
        int d0;

        // Reset state
        @(negedge clk);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_pkt_done", 32'(pkt_done), 32'd0);
        chk("rst_m_tid", 32'(m_tid), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Source 2, three beats; one cycle of arbitration latency
        @(negedge clk);
        d0 = n_done;
        push_src(2, 1, 0, 8'h11); push_src(2, 1, 0, 8'h22); push_src(2, 1, 1, 8'h33);
        push_exp(2, 8'h11, 0); push_exp(2, 8'h22, 0); push_exp(2, 8'h33, 1);
        @(negedge clk);
        chk("t1_latency_idle", 32'(m_tvalid), 32'd0);
        @(negedge clk);
        chk("t1_first_valid", 32'(m_tvalid), 32'd1);
        chk("t1_tid", 32'(m_tid), 32'd2);
        wait_empty("t1_drain");
        chk("t1_done_pulses", 32'(n_done - d0), 32'd1);

        // All four sources streaming from reset: 0,1,2,3,0 with bubbles
        do_reset();
        @(negedge clk);
        c0 = cyc;
        for (int s = 0; s < 4; s++) begin
            push_src(s, 1, 0, 8'(s * 16));
            push_src(s, 1, 1, 8'(s * 16 + 1));
        end
        push_src(0, 1, 0, 8'h04); push_src(0, 1, 1, 8'h05);
        for (int s = 0; s < 4; s++) begin
            push_exp(2'(s), 8'(s * 16), 0);
            push_exp(2'(s), 8'(s * 16 + 1), 1);
        end
        push_exp(0, 8'h04, 0); push_exp(0, 8'h05, 1);
        wait_empty("t2_drain");
        chk("t2_total_cycles", 32'(last_done_cyc - c0), 32'd15);

        // Source 1 granted (with a valid gap); source 0 requests mid-packet
        @(negedge clk);
        push_src(1, 1, 0, 8'h31); push_src(1, 0, 0, 8'h00);
        push_src(1, 1, 0, 8'h32); push_src(1, 1, 1, 8'h33);
        push_exp(1, 8'h31, 0); push_exp(1, 8'h32, 0); push_exp(1, 8'h33, 1);
        repeat (2) @(negedge clk);
        chk("t3_granted_tid", 32'(m_tid), 32'd1);
        push_src(0, 1, 0, 8'h41); push_src(0, 1, 1, 8'h42);
        push_exp(0, 8'h41, 0); push_exp(0, 8'h42, 1);
        @(negedge clk);
        chk("t3_gap_tvalid", 32'(m_tvalid), 32'd0);
        chk("t3_gap_tid", 32'(m_tid), 32'd1);
        chk("t3_src0_blocked", 32'(s_tready[0]), 32'd0);
        wait_empty("t3_drain");

        // Backpressure 1,0,0,1 during a four-beat packet
        @(negedge clk);
        for (int b = 0; b < 4; b++) push_src(2, 1, (b == 3), 8'(8'hA0 + b));
        for (int b = 0; b < 4; b++) push_exp(2, 8'(8'hA0 + b), (b == 3));
        repeat (2) @(negedge clk);
        @(posedge clk); #1 m_trdy = 1'b0;
        @(negedge clk);
        chk("t4_stall_ready", 32'(s_tready), 32'd0);
        chk("t4_stall_data1", 32'(m_tdata), 32'hA1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_stall_data2", 32'(m_tdata), 32'hA1);
        @(posedge clk); #1 m_trdy = 1'b1;
        wait_empty("t4_drain");

        // Reset during the second beat of a five-beat packet
        @(negedge clk);
        for (int b = 0; b < 5; b++) push_src(1, 1, (b == 4), 8'(8'hB0 + b));
        push_exp(1, 8'hB0, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("t5_rst_ready", 32'(s_tready), 32'd0);
        chk("t5_rst_pkt_done", 32'(pkt_done), 32'd0);
        shead[1] = stail[1];
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        push_src(0, 1, 0, 8'hC0); push_src(0, 1, 1, 8'hC1);
        push_src(3, 1, 1, 8'hD0);
        push_exp(0, 8'hC0, 0); push_exp(0, 8'hC1, 1); push_exp(3, 8'hD0, 1);
        wait_empty("t5_drain");

        // Single-beat packet from source 3
        @(negedge clk);
        d0 = n_done;
        push_src(3, 1, 1, 8'hA5);
        push_exp(3, 8'hA5, 1);
        repeat (2) @(negedge clk);
        chk("t6_single_done", 32'(pkt_done), 32'd1);
        chk("t6_single_tid", 32'(m_tid), 32'd3);
        @(negedge clk);
        chk("t6_idle_tvalid", 32'(m_tvalid), 32'd0);
        chk("t6_idle_ready", 32'(s_tready), 32'd0);
        wait_empty("t6_drain");
        chk("t6_done_pulses", 32'(n_done - d0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
